// File: rtl/mem_pkg.sv
// Shared memory-access definitions for the RAM arbiter.
// - funct3 codes for the supported load/store subset (sb, sw, lw, lbu)
// - requester ids used by the round-robin picker
// - byte/word address split constants and the registered response record
// - legality check for a data-port access
package mem_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;

  // Byte address = {word index, byte offset}
  localparam int BYTE_OFF_W = 2;
  localparam int WORD_LSB   = BYTE_OFF_W;

  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // Word accesses must be aligned; byte accesses may sit anywhere.
  // Any funct3 outside the supported subset is rejected.
  function automatic logic d_bad(input logic we, input logic [2:0] f3,
                                 input logic [BYTE_OFF_W-1:0] off);
    logic aligned;
    aligned = (off == '0);
    if (we) return !((f3 == F3_SB) || (f3 == F3_SW && aligned));
    else    return !((f3 == F3_LBU) || (f3 == F3_LW && aligned));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_if, req_d   requests from fetch and data ports
//   gnt_if, gnt_d   one-hot combinational grant (none while rst)
// On a tie the port not granted last wins; after reset the last
// grant counts as IF, so D wins the first tie.
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  port_e last_gnt;

  always_ff @(posedge clk) begin
    if (rst)         last_gnt <= PORT_IF;
    else if (gnt_if) last_gnt <= PORT_IF;
    else if (gnt_d)  last_gnt <= PORT_D;
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    if (!rst) begin
      if (req_if && req_d) begin
        gnt_d  = (last_gnt == PORT_IF);
        gnt_if = (last_gnt == PORT_D);
      end else begin
        gnt_if = req_if;
        gnt_d  = req_d;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port word RAM between instruction fetch (IF) and
// the load/store data port (D). One access per cycle, round-robin.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_err fetch grant and registered response
//   d_req/d_we/d_func/d_addr/d_wdata data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata/d_err     data grant and registered response
//   weram/oeram/func/addr10/addr/R2  RAM drive (addr is a word index)
//   ramout                           RAM async read data
// Responses arrive one cycle after the grant; erroneous accesses never
// enable the RAM and answer with err=1, rdata=0.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_func,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  weram,
  output logic                  oeram,
  output logic [2:0]            func,
  output logic [BYTE_OFF_W-1:0] addr10,
  output logic [31:0]           addr,
  output logic [31:0]           R2,
  input  logic [31:0]           ramout
);

  logic  ierr, derr;
  logic  [7:0] load_byte;
  resp_t if_nxt, d_nxt, if_q, d_q;

  // Address bits above the RAM window are ignored by design.
  logic unused_hi;
  assign unused_hi = ^{if_addr[31:ADDR_BITS+WORD_LSB], d_addr[31:ADDR_BITS+WORD_LSB]};

  function automatic logic [31:0] word_idx(input logic [31:0] a);
    return {{(32-ADDR_BITS){1'b0}}, a[ADDR_BITS+WORD_LSB-1:WORD_LSB]};
  endfunction

  assign ierr = (if_addr[BYTE_OFF_W-1:0] != '0);
  assign derr = d_bad(d_we, d_func, d_addr[BYTE_OFF_W-1:0]);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_if (if_req),
    .req_d  (d_req),
    .gnt_if (if_gnt),
    .gnt_d  (d_gnt)
  );

  // RAM drive for the granted port; all-zero when idle or in reset
  // (the arbiter never grants during rst).
  always_comb begin
    weram  = 1'b0;
    oeram  = 1'b0;
    func   = '0;
    addr10 = '0;
    addr   = '0;
    R2     = '0;
    if (d_gnt) begin
      addr   = word_idx(d_addr);
      addr10 = d_addr[BYTE_OFF_W-1:0];
      func   = d_func;
      R2     = d_wdata;
      weram  = d_we & ~derr;
      oeram  = ~d_we & ~derr;
    end else if (if_gnt) begin
      addr  = word_idx(if_addr);
      func  = F3_LW;
      oeram = ~ierr;
    end
  end

  always_comb begin
    case (d_addr[BYTE_OFF_W-1:0])
      2'd0:    load_byte = ramout[7:0];
      2'd1:    load_byte = ramout[15:8];
      2'd2:    load_byte = ramout[23:16];
      default: load_byte = ramout[31:24];
    endcase
  end

  // Response is captured from the async read data in the grant cycle.
  always_comb begin
    if_nxt.valid = if_gnt;
    if_nxt.err   = if_gnt & ierr;
    if_nxt.rdata = (if_gnt && !ierr) ? ramout : '0;

    d_nxt.valid = d_gnt;
    d_nxt.err   = d_gnt & derr;
    d_nxt.rdata = '0;
    if (d_gnt && !derr && !d_we)
      d_nxt.rdata = (d_func == F3_LBU) ? {24'b0, load_byte} : ramout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_q <= '0;
      d_q  <= '0;
    end else begin
      if_q <= if_nxt;
      d_q  <= d_nxt;
    end
  end

  assign if_rvalid = if_q.valid;
  assign if_err    = if_q.err;
  assign if_rdata  = if_q.rdata;
  assign d_rvalid  = d_q.valid;
  assign d_err     = d_q.err;
  assign d_rdata   = d_q.rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a 64-word RAM model, a behavioural reference
// (grant choice, RAM drive, expected responses, shadow memory) checked
// every cycle, directed scenarios with literal expectations, then
// randomized traffic with occasional resets.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [2:0]  d_func = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        weram, oeram;
  logic [2:0]  func;
  logic [1:0]  addr10;
  logic [31:0] addr, R2, ramout;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.ADDR_BITS(20)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .weram(weram), .oeram(oeram), .func(func), .addr10(addr10),
    .addr(addr), .R2(R2), .ramout(ramout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  // RAM model: async read, posedge write, sw whole word / sb one byte
  logic        ram_init = 1'b1;
  logic [31:0] ram [0:63];
  assign ramout = ram[addr[5:0]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= pat(i);
    end else if (weram) begin
      if (func == 3'b010)      ram[addr[5:0]] <= R2;
      else if (func == 3'b000) ram[addr[5:0]][8*addr10 +: 8] <= R2[7:0];
    end
  end

  // Reference model, evaluated mid-cycle when inputs are stable
  logic [31:0] ref_mem [0:63];
  bit          chk_en = 1'b0;
  bit          m_last_d = 1'b0;
  logic        e_ifv = 0, e_ife = 0, e_dv = 0, e_de = 0;
  logic [31:0] e_ifr = 0, e_dr = 0;

  always @(negedge clk) begin
    bit gi, gd, ierr, derr, legal, e_we, e_oe;
    logic [2:0]  e_fn;
    logic [1:0]  e_off;
    logic [31:0] e_ad, e_r2;
    int wi, sh;

    if (chk_en) begin
      chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
      chk("if_err",    32'(if_err),    32'(e_ife));
      chk("if_rdata",  if_rdata,       e_ifr);
      chk("d_rvalid",  32'(d_rvalid),  32'(e_dv));
      chk("d_err",     32'(d_err),     32'(e_de));
      chk("d_rdata",   d_rdata,        e_dr);
    end
    if (ram_init) for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);

    gi = 0; gd = 0;
    if (!rst) begin
      if (if_req && d_req) begin gd = !m_last_d; gi = m_last_d; end
      else begin gi = if_req; gd = d_req; end
    end
    chk("if_gnt", 32'(if_gnt), 32'(gi));
    chk("d_gnt",  32'(d_gnt),  32'(gd));

    ierr = (if_addr % 4) != 0;
    if (d_we) legal = (d_func == 3'b000) || (d_func == 3'b010 && d_addr % 4 == 0);
    else      legal = (d_func == 3'b100) || (d_func == 3'b010 && d_addr % 4 == 0);
    derr = !legal;

    e_we = 0; e_oe = 0; e_fn = 0; e_off = 0; e_ad = 0; e_r2 = 0;
    if (gd) begin
      e_ad = (d_addr / 4) % 32'h100000; e_off = d_addr[1:0]; e_fn = d_func;
      e_r2 = d_wdata; e_we = d_we && legal; e_oe = !d_we && legal;
    end else if (gi) begin
      e_ad = (if_addr / 4) % 32'h100000; e_fn = 3'b010; e_oe = !ierr;
    end
    chk("weram",  32'(weram),  32'(e_we));
    chk("oeram",  32'(oeram),  32'(e_oe));
    chk("func",   32'(func),   32'(e_fn));
    chk("addr10", 32'(addr10), 32'(e_off));
    chk("addr",   addr,        e_ad);
    if (!gi) chk("R2", R2, e_r2);

    e_ifv = gi; e_ife = gi && ierr; e_ifr = 0;
    if (gi && !ierr) e_ifr = ref_mem[int'((if_addr / 4) % 64)];
    e_dv = gd; e_de = gd && derr; e_dr = 0;
    if (gd && legal) begin
      wi = int'((d_addr / 4) % 64);
      sh = 8 * int'(d_addr % 4);
      if (!d_we) begin
        if (d_func == 3'b010) e_dr = ref_mem[wi];
        else                  e_dr = (ref_mem[wi] >> sh) & 32'hFF;
      end else if (d_func == 3'b010) ref_mem[wi] = d_wdata;
      else ref_mem[wi] = (ref_mem[wi] & ~(32'hFF << sh)) | ({24'b0, d_wdata[7:0]} << sh);
    end
    if (gi || gd) m_last_d = gd;
    if (rst) begin
      m_last_d = 0; chk_en = 1;
      e_ifv = 0; e_ife = 0; e_ifr = 0; e_dv = 0; e_de = 0; e_dr = 0;
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  // One data access from an otherwise idle bench
  task automatic d_op(input logic we, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output logic g, output logic w,
                      output logic o, output logic [31:0] ad, output logic [2:0] fn,
                      output logic v, output logic e, output logic [31:0] rd);
    d_req = 1; d_we = we; d_func = f; d_addr = a; d_wdata = wd;
    @(negedge clk); g = d_gnt; w = weram; o = oeram; ad = addr; fn = func;
    cyc(); d_req = 0;
    @(negedge clk); v = d_rvalid; e = d_err; rd = d_rdata;
    cyc();
  endtask

  function automatic logic [31:0] rnd_addr(input int align_pct);
    logic [31:0] a;
    a = $urandom_range(0, 255);
    if ($urandom_range(0, 99) < align_pct) a[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) a = a | 32'hFFC0_0000;
    return a;
  endfunction

  initial begin
    logic g, w, o, v, e;
    logic [31:0] ad, rd;
    logic [2:0] fn;

    cyc(); cyc();
    ram_init = 0; rst = 0;

    // sw 0x10
    d_op(1, 3'b010, 32'h10, 32'hDEADBEEF, g, w, o, ad, fn, v, e, rd);
    chk("sw_gnt", 32'(g), 1); chk("sw_weram", 32'(w), 1);
    chk("sw_addr", ad, 4); chk("sw_func", 32'(fn), 2);
    chk("sw_rvalid", 32'(v), 1); chk("sw_err", 32'(e), 0);
    chk("sw_mem", ram[4], 32'hDEADBEEF);
    // sb 0x12
    d_op(1, 3'b000, 32'h12, 32'h000000AA, g, w, o, ad, fn, v, e, rd);
    chk("sb_mem", ram[4], 32'hDEAABEEF);
    // lbu 0x12, lw 0x10
    d_op(0, 3'b100, 32'h12, 0, g, w, o, ad, fn, v, e, rd);
    chk("lbu_rdata", rd, 32'h000000AA);
    d_op(0, 3'b010, 32'h10, 0, g, w, o, ad, fn, v, e, rd);
    chk("lw_rdata", rd, 32'hDEAABEEF);
    // misaligned lw, misaligned sw, bad store func
    d_op(0, 3'b010, 32'h13, 0, g, w, o, ad, fn, v, e, rd);
    chk("mis_lw_gnt", 32'(g), 1); chk("mis_lw_oeram", 32'(o), 0);
    chk("mis_lw_rvalid", 32'(v), 1); chk("mis_lw_err", 32'(e), 1);
    chk("mis_lw_rdata", rd, 0);
    d_op(1, 3'b010, 32'h22, 32'h11111111, g, w, o, ad, fn, v, e, rd);
    chk("mis_sw_weram", 32'(w), 0); chk("mis_sw_err", 32'(e), 1);
    chk("mis_sw_mem", ram[8], pat(8));
    d_op(1, 3'b001, 32'h24, 32'h22222222, g, w, o, ad, fn, v, e, rd);
    chk("bad_f3_err", 32'(e), 1); chk("bad_f3_weram", 32'(w), 0);

    // sw 0x40 then lw 0x40 back to back
    d_req = 1; d_we = 1; d_func = 3'b010; d_addr = 32'h40; d_wdata = 32'h12345678;
    cyc();
    d_we = 0;
    @(negedge clk); chk("b2b_sw_ack", 32'(d_rvalid), 1);
    cyc(); d_req = 0;
    @(negedge clk); chk("b2b_lw_rvalid", 32'(d_rvalid), 1);
    chk("b2b_lw_rdata", d_rdata, 32'h12345678);
    cyc();

    // continuous dual requests after reset: D, IF, D, IF, D, IF
    rst = 1; cyc(); rst = 0;
    if_req = 1; if_addr = 32'h8;
    d_req = 1; d_we = 0; d_func = 3'b010; d_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      logic exp_d;
      exp_d = (i % 2 == 0);
      @(negedge clk);
      chk("fair_d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("fair_if_gnt", 32'(if_gnt), 32'(!exp_d));
      if (i > 0) chk("fair_both_rvalid", 32'(if_rvalid & d_rvalid), 0);
      cyc();
    end
    if_req = 0; d_req = 0;
    cyc();

    // reset during a store request
    d_req = 1; d_we = 1; d_func = 3'b010; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    rst = 1;
    @(negedge clk); chk("rst_d_gnt", 32'(d_gnt), 0); chk("rst_weram", 32'(weram), 0);
    cyc(); rst = 0; d_req = 0;
    @(negedge clk); chk("rst_no_rvalid", 32'(d_rvalid), 0);
    chk("rst_mem", ram[12], pat(12));
    cyc();
    if_req = 1; d_req = 1; d_we = 0;
    @(negedge clk); chk("rst_tie_d", 32'(d_gnt), 1);
    cyc(); if_req = 0; d_req = 0;
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst = ($urandom_range(0, 99) == 0);
      if_req = ($urandom_range(0, 2) != 0);
      if_addr = rnd_addr(85);
      d_req = ($urandom_range(0, 2) != 0);
      d_we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 5);
      if (r <= 1)      d_func = 3'b010;
      else if (r == 2) d_func = 3'b100;
      else if (r == 3) d_func = 3'b000;
      else             d_func = 3'($urandom_range(0, 7));
      d_addr = rnd_addr(60);
      d_wdata = $urandom;
      cyc();
    end
    rst = 0; if_req = 0; d_req = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
